serial_rx: RTL and testbench

//  Deserialiser for the raw LSB-first bitstream produced by the serial transmit block.
//  - Frame format: 1..6 bytes, one bit per clk, no start/stop bits.
//  - Frame boundary comes from an external start strobe.
//  - Received bytes go into a 48-bit buffer; the host reads one byte at a time via sel/get.

---
 rtl/serial_rx_if.sv | 25 ++
 rtl/serial_rx.sv | 132 +++++++++++++
 tb/tb_serial_rx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_if.sv
// Host-side bundle for serial_rx: serial input, frame control and byte readout.
// The master modport is the host/transmitter side, the slave modport is the receiver.
interface serial_rx_if;
  logic       rx;
  logic       start;
  logic [2:0] nbytes;
  logic [2:0] sel;
  logic       get;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       ovr;
  logic       perr;

  modport master (
    output rx, start, nbytes, sel, get, ack,
    input  data, valid, busy, ovr, perr
  );

  modport slave (
    input  rx, start, nbytes, sel, get, ack,
    output data, valid, busy, ovr, perr
  );
endinterface

// File: rtl/serial_rx.sv
// Deserialiser for a raw LSB-first bitstream framed by an external start strobe.
// Optional even-parity check is compiled in with SERIAL_RX_PARITY_EN.
module serial_rx #(
  parameter int MAX_BYTES = 6
) (
  input logic        clk,
  input logic        nRst,
  serial_rx_if.slave bus
);

  localparam int BufW = 8 * MAX_BYTES;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

  state_e            state_q, state_d;
  logic [BufW-1:0]   rxBuf_q, rxBuf_d;
  logic [5:0]        idx_q, idx_d;
  logic [5:0]        len_q, len_d;
  logic [5:0]        endIdx;
  logic [7:0]        data_q, data_d;
  logic              ovr_q, ovr_d;
  logic              perr_q, perr_d;
  logic              startOk;

`ifdef SERIAL_RX_PARITY_EN
  logic              parBit_q, parBit_d;
  assign endIdx = len_q + 6'd1;
`else
  assign endIdx = len_q;
`endif

  assign startOk = bus.start && (bus.nbytes != 3'd0) && (bus.nbytes <= 3'(MAX_BYTES));

  // RECV ends with one tail cycle after the final sample, so valid rises an edge later.
  always_comb begin
    state_d = state_q;
    rxBuf_d = rxBuf_q;
    idx_d   = idx_q;
    len_d   = len_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;
`ifdef SERIAL_RX_PARITY_EN
    parBit_d = parBit_q;
`endif

    case (state_q)
      RECV: begin
        idx_d = idx_q + 6'd1;
        for (int k = 0; k < BufW; k++) begin
          if ((idx_q == 6'(k)) && (idx_q < len_q)) begin
            rxBuf_d[k] = bus.rx;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        if (idx_q == len_q) begin
          parBit_d = bus.rx;
        end
`endif
        if (idx_q == endIdx) begin
          state_d = DONE;
          idx_d   = idx_q;
`ifdef SERIAL_RX_PARITY_EN
          perr_d  = (^rxBuf_q) ^ parBit_q;
`endif
        end
      end
      default: begin
        if (startOk) begin
          state_d = RECV;
          rxBuf_d = '0;
          idx_d   = '0;
          len_d   = {bus.nbytes, 3'b000};
          perr_d  = 1'b0;
          if (state_q == DONE) begin
            ovr_d = !bus.ack;
          end
        end else if ((state_q == DONE) && bus.ack) begin
          state_d = IDLE;
          ovr_d   = 1'b0;
          perr_d  = 1'b0;
        end
      end
    endcase

    if (bus.get) begin
      data_d = 8'h00;
      for (int k = 0; k < MAX_BYTES; k++) begin
        if (bus.sel == 3'(k)) begin
          data_d = rxBuf_q[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      rxBuf_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rxBuf_q <= rxBuf_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!nRst) begin
      parBit_q <= 1'b0;
    end else begin
      parBit_q <= parBit_d;
    end
  end
`endif

  assign bus.data  = data_q;
  assign bus.valid = (state_q == DONE);
  assign bus.busy  = (state_q == RECV);
  assign bus.ovr   = ovr_q;
  assign bus.perr  = perr_q;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: read strobes queue expected bytes, a monitor checks them.
// Status outputs and frame latency are checked directly by the stimulus thread.
module tb_serial_rx;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  serial_rx_if bus();

  serial_rx dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int compared = 0;
  int mismatched = 0;
  logic [7:0] expQ[$];
  string nameQ[$];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {7'd0, act}, {7'd0, exp});
  endtask

  // Drive one cycle of inputs at the falling edge; outputs seen here reflect the previous rising edge.
  task automatic applyStimulus(input logic st, input logic [2:0] nb, input logic r,
                               input logic g, input logic [2:0] s, input logic a);
    @(negedge clk);
    bus.start  = st;
    bus.nbytes = nb;
    bus.rx     = r;
    bus.get    = g;
    bus.sel    = s;
    bus.ack    = a;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic readByte(input logic [2:0] s, input logic [7:0] exp, input string name);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, s, 1'b0);
    expQ.push_back(exp);
    nameQ.push_back(name);
  endtask

  task automatic sendFrame(input int n, input logic [47:0] bits, input logic par,
                           input int injectAt, input logic ackWithStart, input string name);
    applyStimulus(1'b1, 3'(n), 1'b1, 1'b0, 3'd0, ackWithStart);
    for (int i = 0; i < 8*n; i++) begin
      if (i == injectAt) applyStimulus(1'b1, 3'd2, bits[i], 1'b0, 3'd0, 1'b0);
      else               applyStimulus(1'b0, 3'd0, bits[i], 1'b0, 3'd0, 1'b0);
      if (i == 0) begin
        checkBit({name, " busy after start"}, bus.busy, 1'b1);
        checkBit({name, " valid after start"}, bus.valid, 1'b0);
      end
    end
`ifdef SERIAL_RX_PARITY_EN
    applyStimulus(1'b0, 3'd0, par, 1'b0, 3'd0, 1'b0);
`else
    if (par === 1'bx) $display("[TB] note: parity argument unknown");
`endif
    idle();
    checkBit({name, " valid not early"}, bus.valid, 1'b0);
    checkBit({name, " busy in tail"}, bus.busy, 1'b1);
    idle();
    checkBit({name, " valid on time"}, bus.valid, 1'b1);
    checkBit({name, " busy done"}, bus.busy, 1'b0);
  endtask

  // Monitor: every accepted get produces a data update checked one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      if (nRst === 1'b1 && bus.get === 1'b1) begin
        @(negedge clk);
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected read: got 0x%02h, expected no read", bus.data);
        end else begin
          checkOutput(nameQ.pop_front(), bus.data, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    compared++;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    $display("[TB] serial_rx bench starting");
    bus.start = 1'b1; bus.nbytes = 3'd1; bus.rx = 1'b1;
    bus.get = 1'b0; bus.sel = 3'd0; bus.ack = 1'b0;

    // 1: reset held two cycles with start asserted
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checkOutput("reset data", bus.data, 8'h00);
    checkBit("reset valid", bus.valid, 1'b0);
    checkBit("reset busy", bus.busy, 1'b0);
    checkBit("reset ovr", bus.ovr, 1'b0);
    checkBit("reset perr", bus.perr, 1'b0);
    bus.start = 1'b0;
    nRst = 1'b1;
    idle();
    checkBit("post-reset busy", bus.busy, 1'b0);

    // 2: single byte 0xA5
    sendFrame(1, 48'hA5, 1'b0, -1, 1'b0, "A5");
    readByte(3'd0, 8'hA5, "A5 sel0");
    readByte(3'd1, 8'h00, "A5 sel1");
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);
    idle();
    checkBit("A5 ack valid", bus.valid, 1'b0);

    // 3: full six-byte frame
    sendFrame(6, 48'h665544332211, 1'b0, -1, 1'b0, "six");
    for (int k = 0; k < 6; k++) readByte(3'(k), 8'(8'h11 * (k + 1)), "six byte");
    readByte(3'd7, 8'h00, "six sel7");
    readByte(3'd6, 8'h00, "six sel6");
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);
    idle();
    checkBit("six ack valid", bus.valid, 1'b0);
    checkBit("six ack ovr", bus.ovr, 1'b0);

    // 4: illegal lengths and start during reception
    applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    idle();
    checkBit("nbytes0 busy", bus.busy, 1'b0);
    applyStimulus(1'b1, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0);
    idle();
    checkBit("nbytes7 busy", bus.busy, 1'b0);
    sendFrame(1, 48'h5A, 1'b0, 3, 1'b0, "inject");
    readByte(3'd0, 8'h5A, "inject sel0");
    readByte(3'd1, 8'h00, "inject sel1");
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);

    // 5: overrun, then ack clears it
    sendFrame(1, 48'h3C, 1'b0, -1, 1'b0, "3C");
    checkBit("3C ovr", bus.ovr, 1'b0);
    sendFrame(1, 48'hC3, 1'b0, -1, 1'b0, "C3");
    checkBit("C3 ovr set", bus.ovr, 1'b1);
    readByte(3'd0, 8'hC3, "C3 sel0");
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);
    idle();
    checkBit("C3 ack ovr", bus.ovr, 1'b0);
    checkBit("C3 ack valid", bus.valid, 1'b0);

    // ack together with start in DONE does not flag an overrun
    sendFrame(1, 48'hA5, 1'b0, -1, 1'b0, "pre");
    sendFrame(1, 48'h7E, 1'b0, -1, 1'b1, "ackstart");
    checkBit("ackstart ovr", bus.ovr, 1'b0);
    readByte(3'd0, 8'h7E, "ackstart sel0");
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);

    // 6: reset during bit 4 of a two-byte frame
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    nRst = 1'b0;
    idle();
    checkBit("midreset busy", bus.busy, 1'b0);
    checkBit("midreset valid", bus.valid, 1'b0);
    checkOutput("midreset data", bus.data, 8'h00);
    nRst = 1'b1;
    idle();
    checkBit("midreset stays idle", bus.busy, 1'b0);
    readByte(3'd0, 8'h00, "midreset sel0");
    readByte(3'd1, 8'h00, "midreset sel1");

`ifdef SERIAL_RX_PARITY_EN
    sendFrame(1, 48'h01, 1'b0, -1, 1'b0, "par0");
    checkBit("par0 perr", bus.perr, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);
    idle();
    checkBit("par0 ack perr", bus.perr, 1'b0);
    sendFrame(1, 48'h01, 1'b1, -1, 1'b0, "par1");
    checkBit("par1 perr", bus.perr, 1'b0);
`else
    sendFrame(1, 48'h01, 1'b0, -1, 1'b0, "noparity");
    checkBit("noparity perr", bus.perr, 1'b0);
`endif

    idle();
    idle();
    idle();
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL pending reads: got %0d left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
